bc_polinomio: RTL and testbench

- Control block (FSM) that drives the polynomial datapath's select and load signals to evaluate y = A·x² + B·x + C by Horner's rule, or y = B·x + C in linear mode.
- Sits beside the datapath and drives M0, M1, M2, LX, LH, LS and H.
- The host sees a start/busy/done handshake. The result is in the datapath's R2 register when done pulses.

---
 rtl/bc_polinomio_pkg.sv | 45 ++++
 rtl/bc_polinomio_contador_passo.sv | 38 +++
 rtl/bc_polinomio.sv | 110 +++++++++++
 tb/tb_bc_polinomio.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bc_polinomio_pkg.sv
// Shared definitions for the bc_polinomio control block.
// Contents:
//   estado_t        - FSM state encoding (also exported on the estado debug port)
//   SEL_*           - M0 coefficient mux codes (zero, A, B, C)
//   SRC_*           - M1 ALU operand-1 mux codes (M0 output, R0, R1, R2)
//   SRC2_*          - M2 ALU operand-2 mux codes (R0, M0 output, R1, R2)
//   OP_MUL / OP_ADD - ALU operation driven on H
//   CNT_W           - width of the step counter (covers STEP_CYCLES up to 15)
package bc_polinomio_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    AX   = 3'd2,
    AXB  = 3'd3,
    MULX = 3'd4,
    BX   = 3'd5,
    ADDC = 3'd6,
    DONE = 3'd7
  } estado_t;

  // M0: coefficient selection
  localparam logic [1:0] SEL_ZERO = 2'd0;
  localparam logic [1:0] SEL_A    = 2'd1;
  localparam logic [1:0] SEL_B    = 2'd2;
  localparam logic [1:0] SEL_C    = 2'd3;

  // M1: ALU operand 1
  localparam logic [1:0] SRC_M0 = 2'd0;
  localparam logic [1:0] SRC_R0 = 2'd1;
  localparam logic [1:0] SRC_R1 = 2'd2;
  localparam logic [1:0] SRC_R2 = 2'd3;

  // M2: ALU operand 2 (R0 and the M0 output swap places relative to M1)
  localparam logic [1:0] SRC2_R0 = 2'd0;
  localparam logic [1:0] SRC2_M0 = 2'd1;
  localparam logic [1:0] SRC2_R1 = 2'd2;
  localparam logic [1:0] SRC2_R2 = 2'd3;

  localparam logic OP_MUL = 1'b1;
  localparam logic OP_ADD = 1'b0;

  localparam int CNT_W = 4;

endpackage

// File: rtl/bc_polinomio_contador_passo.sv
// Step counter (contador_passo) for bc_polinomio.
// Counts the cycles spent in the current datapath step and flags the last one.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   clr  - restart the step (asserted on every state change and while idle)
//   cnt  - cycles elapsed in the current step, 0-based
//   tc   - terminal count: this is the last cycle of the step
module bc_polinomio_contador_passo
  import bc_polinomio_pkg::*;
#(
  parameter int STEP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 1);

  assign tc = (cnt == LAST);

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (!tc) begin
      // Holds at terminal count; the FSM always leaves or clears the step then.
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bc_polinomio.sv
// Control FSM for the polynomial datapath.
// Evaluates y = A*x^2 + B*x + C by Horner's rule (modo=0) or y = B*x + C
// (modo=1), sequencing the datapath muxes and register loads. Each step is
// held for STEP_CYCLES cycles; load strobes fire only on the last cycle.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   start, modo    - evaluation request and mode (modo latched on accept)
//   M0, M1, M2     - coefficient / ALU operand mux selects
//   LX, LH, LS     - load strobes for R0 (x), R1 (partial), R2 (result)
//   H              - ALU operation, 1 = multiply, 0 = add
//   busy, done     - handshake; done pulses once, R2 valid from next cycle
//   estado         - current state, for debug
module bc_polinomio
  import bc_polinomio_pkg::*;
#(
  parameter int STEP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       modo,
  output logic [1:0] M0,
  output logic [1:0] M1,
  output logic [1:0] M2,
  output logic       LX,
  output logic       LH,
  output logic       LS,
  output logic       H,
  output logic       busy,
  output logic       done,
  output logic [2:0] estado
);

  estado_t          state, state_nx;
  logic             modo_q;
  logic             tc;
  logic [CNT_W-1:0] cnt;

  // Clearing while idle keeps the first step of each evaluation full length.
  bc_polinomio_contador_passo #(.STEP_CYCLES(STEP_CYCLES)) u_passo (
    .clk (clk),
    .rst (rst),
    .clr ((state_nx != state) || (state == IDLE)),
    .cnt (cnt),
    .tc  (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      modo_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) modo_q <= modo;
    end
  end

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = LOAD;
      LOAD: if (tc) state_nx = modo_q ? BX : AX;
      AX:   if (tc) state_nx = AXB;
      AXB:  if (tc) state_nx = MULX;
      MULX: if (tc) state_nx = ADDC;
      BX:   if (tc) state_nx = ADDC;
      ADDC: if (tc) state_nx = DONE;
      DONE: state_nx = IDLE;  // single cycle regardless of STEP_CYCLES
      default: state_nx = IDLE;
    endcase
  end

  // Moore output decode; strobes are qualified by the terminal count.
  always_comb begin
    M0   = SEL_ZERO;
    M1   = SRC_M0;
    M2   = SRC2_R0;
    H    = OP_ADD;
    LX   = 1'b0;
    LH   = 1'b0;
    LS   = 1'b0;
    done = 1'b0;
    busy = (state != IDLE);
    unique case (state)
      LOAD: LX = tc;
      AX: begin                       // R1 = A * x
        M0 = SEL_A;  M1 = SRC_M0; M2 = SRC2_R0; H = OP_MUL; LH = tc;
      end
      AXB: begin                      // R1 = R1 + B
        M0 = SEL_B;  M1 = SRC_R1; M2 = SRC2_M0; H = OP_ADD; LH = tc;
      end
      MULX: begin                     // R1 = R1 * x
        M1 = SRC_R1; M2 = SRC2_R0; H = OP_MUL; LH = tc;
      end
      BX: begin                       // R1 = B * x
        M0 = SEL_B;  M1 = SRC_M0; M2 = SRC2_R0; H = OP_MUL; LH = tc;
      end
      ADDC: begin                     // R2 = R1 + C
        M0 = SEL_C;  M1 = SRC_R1; M2 = SRC2_M0; H = OP_ADD; LS = tc;
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign estado = state;

endmodule

// File: tb/tb_bc_polinomio.sv
// Self-checking bench for bc_polinomio. Two instances (STEP_CYCLES=1 and 3)
// each drive a behavioural model of the polynomial datapath; results are
// compared against y computed directly with 16-bit arithmetic.
module tb_bc_polinomio;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, modo, start0, start1;
  logic [1:0] m0_0, m1_0, m2_0, m0_1, m1_1, m2_1;
  logic lx0, lh0, ls0, h0, busy0, done0;
  logic lx1, lh1, ls1, h1, busy1, done1;
  logic [2:0] est0, est1;

  int checks = 0;
  int errors = 0;

  bc_polinomio #(.STEP_CYCLES(1)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .modo(modo),
    .M0(m0_0), .M1(m1_0), .M2(m2_0), .LX(lx0), .LH(lh0), .LS(ls0), .H(h0),
    .busy(busy0), .done(done0), .estado(est0)
  );

  bc_polinomio #(.STEP_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .start(start1), .modo(modo),
    .M0(m0_1), .M1(m1_1), .M2(m2_1), .LX(lx1), .LH(lh1), .LS(ls1), .H(h1),
    .busy(busy1), .done(done1), .estado(est1)
  );

  // ---------------- datapath model ----------------
  logic [15:0] a_v, b_v, c_v, x_v;
  logic [15:0] r0_0, r1_0, r2_0, r0_1, r1_1, r2_1;

  function automatic logic [15:0] alu_f(input logic [1:0] s0, s1, s2, input logic op,
                                        input logic [15:0] r0, r1, r2);
    logic [15:0] mv, o1, o2;
    case (s0)
      2'd0: mv = 16'd0;
      2'd1: mv = a_v;
      2'd2: mv = b_v;
      default: mv = c_v;
    endcase
    case (s1)
      2'd0: o1 = mv;
      2'd1: o1 = r0;
      2'd2: o1 = r1;
      default: o1 = r2;
    endcase
    case (s2)
      2'd0: o2 = r0;
      2'd1: o2 = mv;
      2'd2: o2 = r1;
      default: o2 = r2;
    endcase
    return op ? o1 * o2 : o1 + o2;
  endfunction

  always @(posedge clk) begin
    if (lx0) r0_0 <= x_v;
    if (lh0) r1_0 <= alu_f(m0_0, m1_0, m2_0, h0, r0_0, r1_0, r2_0);
    if (ls0) r2_0 <= alu_f(m0_0, m1_0, m2_0, h0, r0_0, r1_0, r2_0);
    if (lx1) r0_1 <= x_v;
    if (lh1) r1_1 <= alu_f(m0_1, m1_1, m2_1, h1, r0_1, r1_1, r2_1);
    if (ls1) r2_1 <= alu_f(m0_1, m1_1, m2_1, h1, r0_1, r1_1, r2_1);
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] ref_y(input logic [15:0] a, b, c, x, input logic m);
    logic [15:0] r;
    if (m) r = b * x + c;
    else   r = a * x * x + b * x + c;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap(input int k, output logic [2:0] st, output logic lx, lh, ls, bz, dn,
                      output logic [15:0] r2);
    if (k == 0) begin
      st = est0; lx = lx0; lh = lh0; ls = ls0; bz = busy0; dn = done0; r2 = r2_0;
    end else begin
      st = est1; lx = lx1; lh = lh1; ls = ls1; bz = busy1; dn = done1; r2 = r2_1;
    end
  endtask

  // One full evaluation on instance k; modo is flipped right after accept
  // to show only the latched copy matters.
  task automatic eval(input int k, input logic [15:0] a, b, c, x, input logic m,
                      input string tag);
    int s, n, pos, nlx, nlh, nls, nbusy_lo, exp_lat;
    logic seen, lx, lh, ls, bz, dn;
    logic [2:0] st, prev;
    logic [15:0] r2, y;
    string seq, exp_seq;
    s = (k == 0) ? 1 : 3;
    exp_lat = m ? 3 * s + 1 : 5 * s + 1;
    exp_seq = m ? "1 5 6 7" : "1 2 3 4 6 7";
    y = ref_y(a, b, c, x, m);
    a_v = a; b_v = b; c_v = c; x_v = x; modo = m;
    if (k == 0) start0 = 1'b1; else start1 = 1'b1;
    n = 0; pos = 0; nlx = 0; nlh = 0; nls = 0; nbusy_lo = 0;
    seen = 1'b0; prev = 3'd0; seq = "";
    while (!seen && n < 100) begin
      tick();
      n++;
      if (n == 1) begin
        start0 = 1'b0; start1 = 1'b0; modo = ~m;
      end
      snap(k, st, lx, lh, ls, bz, dn, r2);
      if (st != prev) begin
        pos = 0;
        seq = (seq == "") ? $sformatf("%0d", st) : {seq, " ", $sformatf("%0d", st)};
      end else begin
        pos++;
      end
      prev = st;
      if (lx || lh || ls) begin
        checks++;
        if (pos !== s - 1) begin
          errors++;
          $display("FAIL %s strobe_pos: state %0d strobe at step cycle %0d, required %0d",
                   tag, st, pos, s - 1);
        end
      end
      nlx += int'(lx); nlh += int'(lh); nls += int'(ls);
      if (!bz) nbusy_lo++;
      if (dn) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s timeout: no done within %0d cycles, required %0d", tag, n, exp_lat);
      return;
    end
    if (n !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, required %0d", tag, n, exp_lat);
    end
    checks++;
    if (seq != exp_seq) begin
      errors++;
      $display("FAIL %s state_seq: got '%s', required '%s'", tag, seq, exp_seq);
    end
    checks++;
    if (nlx !== 1 || nlh !== (m ? 1 : 3) || nls !== 1) begin
      errors++;
      $display("FAIL %s strobe_count: LX/LH/LS %0d/%0d/%0d, required 1/%0d/1",
               tag, nlx, nlh, nls, m ? 1 : 3);
    end
    checks++;
    if (nbusy_lo !== 0) begin
      errors++;
      $display("FAIL %s busy: low in %0d cycles of the evaluation, required 0", tag, nbusy_lo);
    end
    tick();
    snap(k, st, lx, lh, ls, bz, dn, r2);
    checks++;
    if (r2 !== y) begin
      errors++;
      $display("FAIL %s result: R2=%h, required %h", tag, r2, y);
    end
    checks++;
    if (st !== 3'd0 || bz !== 1'b0 || dn !== 1'b0) begin
      errors++;
      $display("FAIL %s back_to_idle: estado=%0d busy=%b done=%b, required 0/0/0",
               tag, st, bz, dn);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; modo = 1'b0;
    tick(); tick();
    checks++;
    if ({m0_0, m1_0, m2_0, lx0, lh0, ls0, h0, busy0, done0, est0} !== 16'd0) begin
      errors++;
      $display("FAIL reset_s1: outputs %h, required 0",
               {m0_0, m1_0, m2_0, lx0, lh0, ls0, h0, busy0, done0, est0});
    end
    checks++;
    if ({m0_1, m1_1, m2_1, lx1, lh1, ls1, h1, busy1, done1, est1} !== 16'd0) begin
      errors++;
      $display("FAIL reset_s3: outputs %h, required 0",
               {m0_1, m1_1, m2_1, lx1, lh1, ls1, h1, busy1, done1, est1});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_quadratic();
    eval(0, 16'd3, 16'd2, 16'd5, 16'd2, 1'b0, "quad_s1");
  endtask

  task automatic test_linear();
    eval(0, 16'd3, 16'd2, 16'd5, 16'd2, 1'b1, "lin_s1");
  endtask

  task automatic test_step3();
    eval(1, 16'd1, 16'd0, 16'd7, 16'd4, 1'b0, "quad_s3");
    eval(1, 16'd9, 16'd6, 16'd3, 16'd5, 1'b1, "lin_s3");
  endtask

  task automatic test_overflow();
    eval(0, 16'h0100, 16'h0000, 16'h0001, 16'h0100, 1'b0, "overflow");
  endtask

  task automatic test_back_to_back();
    int times[$];
    logic prev_done;
    a_v = 16'd3; b_v = 16'd2; c_v = 16'd5; x_v = 16'd2;
    modo = 1'b1; start0 = 1'b1; prev_done = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (prev_done) begin
        checks++;
        if (est0 !== 3'd0) begin
          errors++;
          $display("FAIL b2b_start_in_done: estado=%0d after DONE, required 0", est0);
        end
      end
      if (done0) times.push_back(n);
      prev_done = done0;
    end
    start0 = 1'b0;
    checks++;
    if (times.size() !== 4) begin
      errors++;
      $display("FAIL b2b_count: %0d done pulses, required 4", times.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (times[i] !== 4 + 5 * i) begin
          errors++;
          $display("FAIL b2b_time: done #%0d at cycle %0d, required %0d", i, times[i], 4 + 5 * i);
        end
      end
    end
    for (int i = 0; i < 10 && est0 != 3'd0; i++) tick();
    checks++;
    if (r2_0 !== ref_y(16'd3, 16'd2, 16'd5, 16'd2, 1'b1) || est0 !== 3'd0) begin
      errors++;
      $display("FAIL b2b_result: R2=%h estado=%0d, required %h in IDLE", r2_0, est0,
               ref_y(16'd3, 16'd2, 16'd5, 16'd2, 1'b1));
    end
  endtask

  task automatic test_reset_mid();
    int n;
    logic saw_done;
    a_v = 16'd3; b_v = 16'd2; c_v = 16'd5; x_v = 16'd2;
    modo = 1'b0; start0 = 1'b1; n = 0;
    while (est0 != 3'd4 && n < 20) begin
      tick(); n++; start0 = 1'b0;
    end
    checks++;
    if (est0 !== 3'd4) begin
      errors++;
      $display("FAIL rstmid_reach: estado=%0d, required 4 (MULX)", est0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({m0_0, m1_0, m2_0, lx0, lh0, ls0, h0, busy0, done0, est0} !== 16'd0) begin
      errors++;
      $display("FAIL rstmid_outputs: %h, required 0",
               {m0_0, m1_0, m2_0, lx0, lh0, ls0, h0, busy0, done0, est0});
    end
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done0 || est0 != 3'd0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL rstmid_no_done: activity after abort, required idle");
    end
    eval(0, 16'd3, 16'd2, 16'd5, 16'd2, 1'b0, "after_rst");
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      logic [15:0] a, b, c, x;
      a = 16'($urandom); b = 16'($urandom); c = 16'($urandom);
      x = (i < 4) ? 16'($urandom_range(0, 15)) : 16'($urandom);
      eval(int'($urandom_range(0, 1)), a, b, c, x, 1'($urandom_range(0, 1)),
           $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_quadratic();
    test_linear();
    test_step3();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
